// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if
//   Groups the request/operand and status/result signals of mul_sequencer.
//   master : drives start, x, y; observes busy, done, hi, lo
//   slave  : the multiplier itself (inverse directions)
//   start  : request a new multiply (accepted in IDLE or DONE)
//   x, y   : signed 32-bit operands, sampled only on the accepting edge
//   busy   : high while the multiply is iterating
//   done   : one-cycle completion pulse
//   hi, lo : upper/lower 32 bits of the last completed 64-bit product
interface mul_sequencer_if;
   logic        start;
   logic [31:0] x;
   logic [31:0] y;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, x, y, input busy, done, hi, lo);
   modport slave  (input start, x, y, output busy, done, hi, lo);
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer
//   Sequential signed 32x32 -> 64 multiplier using radix-4 Booth recoding,
//   one partial product per clock, 16 iterations per multiply.
//   clock : rising-edge clock for all state
//   clear : synchronous active-high reset
//   bus   : mul_sequencer_if.slave (start/x/y in, busy/done/hi/lo out)
//   Timing: accepting edge E0, RUN edges E1..E16 process digits 0..15,
//   done is high in the cycle after E16. Holding start gives one result
//   every 17 cycles.
module mul_sequencer (
   input  logic           clock,
   input  logic           clear,
   mul_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_reg, state_next;
   logic        accept;
   logic [3:0]  count_reg;
   logic [31:0] x_reg, y_reg;
   logic [63:0] acc_reg;
   logic [31:0] hi_reg, lo_reg;
   logic        busy_reg, done_reg;

   // ---------------- Booth digit selection ----------------
   // y extended with the implicit y[-1]=0 below bit 0, so triplet k is
   // y_ext[2k+2:2k] = {y[2k+1], y[2k], y[2k-1]}.
   logic [32:0] y_ext;
   logic [2:0]  triplet [16];
   logic [2:0]  booth_sel;

   assign y_ext = {y_reg, 1'b0};

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_triplet
         assign triplet[gi] = y_ext[2*gi+2 -: 3];
      end
   endgenerate

   assign booth_sel = triplet[count_reg];

   // 34 bits hold +-2x for every 32-bit x, including -2 * 0x80000000.
   logic [33:0] x34;
   logic [33:0] pp;
   logic [63:0] pp_ext;
   logic [63:0] acc_sum;

   assign x34 = {{2{x_reg[31]}}, x_reg};

   always_comb begin
      pp = '0;
      case (booth_sel)
         3'b001, 3'b010: pp = x34;
         3'b011:         pp = x34 << 1;
         3'b100:         pp = -(x34 << 1);
         3'b101, 3'b110: pp = -x34;
         default:        pp = '0;
      endcase
   end

   assign pp_ext  = {{30{pp[33]}}, pp};
   assign acc_sum = acc_reg + (pp_ext << {count_reg, 1'b0});

   // ---------------- FSM next state ----------------
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next = RUN;
               accept     = 1'b1;
            end
         end
         RUN: begin
            if (count_reg == 4'd15) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               state_next = RUN;
               accept     = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- State and datapath registers ----------------
   always_ff @(posedge clock) begin
      if (clear) begin
         state_reg <= IDLE;
         count_reg <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         acc_reg   <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         // Status flags registered from the next state so they line up
         // exactly with the state they describe.
         busy_reg  <= (state_next == RUN);
         done_reg  <= (state_next == DONE);
         if (accept) begin
            x_reg     <= bus.x;
            y_reg     <= bus.y;
            acc_reg   <= '0;
            count_reg <= '0;
         end else if (state_reg == RUN) begin
            acc_reg   <= acc_sum;
            count_reg <= count_reg + 4'd1;  // wraps to 0 after digit 15
            if (count_reg == 4'd15) begin
               hi_reg <= acc_sum[63:32];
               lo_reg <= acc_sum[31:0];
            end
         end
      end
   end

   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.hi   = hi_reg;
   assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer
//   Directed bench for mul_sequencer: reset, single multiply with latency,
//   corner-case operand vectors, start ignored during RUN, clear abort,
//   and back-to-back operation with start held high.
module tb_mul_sequencer;

   logic clk;
   logic clear;
   int   checks;
   int   failures;

   mul_sequencer_if mif ();

   mul_sequencer dut (
      .clock (clk),
      .clear (clear),
      .bus   (mif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Operand / expected-product table (hand computed).
   logic [31:0] vx  [6];
   logic [31:0] vy  [6];
   logic [31:0] vhi [6];
   logic [31:0] vlo [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      mif.start = 1'b1;
      mif.x     = a;
      mif.y     = b;
      step();
      mif.start = 1'b0;
   endtask

   // Steps until done is seen or the bound expires; returns steps taken.
   task automatic wait_done(output int n);
      n = 0;
      while (mif.done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      clear     = 1'b1;
      mif.start = 1'b1;   // clear must win over start
      mif.x     = 32'd1;
      mif.y     = 32'd1;
      step();
      step();
      checks++;
      if ({mif.busy, mif.done} !== 2'b00) begin
         failures++;
         $display("FAIL reset_flags: busy/done=%b expected 00", {mif.busy, mif.done});
      end
      checks++;
      if ({mif.hi, mif.lo} !== 64'd0) begin
         failures++;
         $display("FAIL reset_result: got %h expected 0", {mif.hi, mif.lo});
      end
      mif.start = 1'b0;
      clear     = 1'b0;
      step();
      checks++;
      if (mif.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b expected 0", mif.busy);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      int busy_cnt;
      start_op(32'd7, 32'hFFFF_FFFD);
      busy_cnt = (mif.busy === 1'b1) ? 1 : 0;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (mif.busy === 1'b1) busy_cnt++;
         checks++;
         if (mif.done !== 1'b0 || {mif.hi, mif.lo} !== 64'd0) begin
            failures++;
            $display("FAIL basic_run_hold: cycle %0d done=%b result=%h expected 0/0",
                     i, mif.done, {mif.hi, mif.lo});
         end
      end
      step();
      checks++;
      if (mif.done !== 1'b1 || mif.busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_latency: done=%b busy=%b expected done=1 busy=0 at E16+1",
                  mif.done, mif.busy);
      end
      checks++;
      if (mif.hi !== 32'hFFFF_FFFF || mif.lo !== 32'hFFFF_FFEB) begin
         failures++;
         $display("FAIL basic_product: got %h_%h expected ffffffff_ffffffeb", mif.hi, mif.lo);
      end
      checks++;
      if (busy_cnt != 16) begin
         failures++;
         $display("FAIL basic_busy_len: got %0d expected 16", busy_cnt);
      end
      step();
      checks++;
      if (mif.done !== 1'b0 || mif.busy !== 1'b0 || mif.lo !== 32'hFFFF_FFEB) begin
         failures++;
         $display("FAIL basic_after: done=%b busy=%b lo=%h expected 0 0 ffffffeb",
                  mif.done, mif.busy, mif.lo);
      end
      $display("test_basic 7*-3 -> %h_%h", mif.hi, mif.lo);
   endtask

   task automatic test_vectors();
      int n;
      vx[0] = 32'h8000_0000; vy[0] = 32'h8000_0000; vhi[0] = 32'h4000_0000; vlo[0] = 32'h0000_0000;
      vx[1] = 32'h7FFF_FFFF; vy[1] = 32'h8000_0000; vhi[1] = 32'hC000_0000; vlo[1] = 32'h8000_0000;
      vx[2] = 32'h0000_3039; vy[2] = 32'hFFFF_FFFF; vhi[2] = 32'hFFFF_FFFF; vlo[2] = 32'hFFFF_CFC7;
      vx[3] = 32'h0001_0000; vy[3] = 32'h0001_0000; vhi[3] = 32'h0000_0001; vlo[3] = 32'h0000_0000;
      vx[4] = 32'hFFFF_FFFF; vy[4] = 32'h0000_0000; vhi[4] = 32'h0000_0000; vlo[4] = 32'h0000_0000;
      vx[5] = 32'h7FFF_FFFF; vy[5] = 32'h7FFF_FFFF; vhi[5] = 32'h3FFF_FFFF; vlo[5] = 32'h0000_0001;
      for (int v = 0; v < 6; v++) begin
         start_op(vx[v], vy[v]);
         wait_done(n);
         checks++;
         if (n != 16) begin
            failures++;
            $display("FAIL vec%0d_latency: got %0d cycles expected 16", v, n);
         end
         checks++;
         if (mif.hi !== vhi[v] || mif.lo !== vlo[v]) begin
            failures++;
            $display("FAIL vec%0d_product: %h*%h got %h_%h expected %h_%h",
                     v, vx[v], vy[v], mif.hi, mif.lo, vhi[v], vlo[v]);
         end
         $display("test_vectors %h*%h -> %h_%h", vx[v], vy[v], mif.hi, mif.lo);
         step();
      end
   endtask

   task automatic test_start_ignored();
      int pulses;
      int overlap;
      start_op(32'd5, 32'd6);
      step();
      step();
      mif.start = 1'b1;
      mif.x     = 32'd9;
      mif.y     = 32'd9;
      step();
      mif.start = 1'b0;
      mif.x     = 32'hDEAD_BEEF;
      mif.y     = 32'h1234_5678;
      pulses  = 0;
      overlap = 0;
      for (int i = 0; i < 25; i++) begin
         if (mif.done === 1'b1) pulses++;
         if (mif.done === 1'b1 && mif.busy === 1'b1) overlap++;
         step();
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL ignore_pulses: got %0d done pulses expected 1", pulses);
      end
      checks++;
      if (overlap != 0) begin
         failures++;
         $display("FAIL ignore_overlap: busy and done high together %0d times expected 0", overlap);
      end
      checks++;
      if (mif.hi !== 32'd0 || mif.lo !== 32'd30) begin
         failures++;
         $display("FAIL ignore_product: got %h_%h expected 00000000_0000001e", mif.hi, mif.lo);
      end
      $display("test_start_ignored 5*6 -> %h_%h pulses=%0d", mif.hi, mif.lo, pulses);
   endtask

   task automatic test_clear_abort();
      int n;
      int pulses;
      int busy_seen;
      start_op(32'd3, 32'd4);
      wait_done(n);
      checks++;
      if (n != 16 || mif.lo !== 32'd12 || mif.hi !== 32'd0) begin
         failures++;
         $display("FAIL clear_first: cycles=%0d got %h_%h expected 16 00000000_0000000c",
                  n, mif.hi, mif.lo);
      end
      step();
      start_op(32'd2, 32'd2);
      for (int i = 0; i < 4; i++) step();
      clear     = 1'b1;
      mif.start = 1'b1;
      step();
      clear     = 1'b0;
      mif.start = 1'b0;
      checks++;
      if (mif.busy !== 1'b0 || mif.done !== 1'b0 || {mif.hi, mif.lo} !== 64'd0) begin
         failures++;
         $display("FAIL clear_abort: busy=%b done=%b result=%h expected 0 0 0",
                  mif.busy, mif.done, {mif.hi, mif.lo});
      end
      pulses    = 0;
      busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (mif.done === 1'b1) pulses++;
         if (mif.busy === 1'b1) busy_seen++;
      end
      checks++;
      if (pulses != 0 || busy_seen != 0) begin
         failures++;
         $display("FAIL clear_quiet: done pulses=%0d busy cycles=%0d expected 0 0", pulses, busy_seen);
      end
      start_op(32'd2, 32'd2);
      wait_done(n);
      checks++;
      if (n != 16 || mif.hi !== 32'd0 || mif.lo !== 32'd4) begin
         failures++;
         $display("FAIL clear_restart: cycles=%0d got %h_%h expected 16 00000000_00000004",
                  n, mif.hi, mif.lo);
      end
      $display("test_clear_abort restart 2*2 -> %h_%h", mif.hi, mif.lo);
      step();
   endtask

   task automatic test_back_to_back();
      int n1;
      int n2;
      mif.start = 1'b1;
      mif.x     = 32'd1;
      mif.y     = 32'd1;
      step();
      mif.x = 32'hFFFF_FFFF;
      mif.y = 32'hFFFF_FFFF;
      wait_done(n1);
      checks++;
      if (n1 != 16 || mif.hi !== 32'd0 || mif.lo !== 32'd1) begin
         failures++;
         $display("FAIL b2b_first: cycles=%0d got %h_%h expected 16 00000000_00000001",
                  n1, mif.hi, mif.lo);
      end
      step();
      checks++;
      if (mif.busy !== 1'b1 || mif.done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_no_idle: busy=%b done=%b expected busy=1 done=0", mif.busy, mif.done);
      end
      wait_done(n2);
      mif.start = 1'b0;
      checks++;
      if (n2 + 1 != 17) begin
         failures++;
         $display("FAIL b2b_spacing: done pulses %0d cycles apart expected 17", n2 + 1);
      end
      checks++;
      if (mif.hi !== 32'd0 || mif.lo !== 32'd1) begin
         failures++;
         $display("FAIL b2b_second: got %h_%h expected 00000000_00000001", mif.hi, mif.lo);
      end
      step();
      checks++;
      if (mif.busy !== 1'b0 || mif.done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_stop: busy=%b done=%b expected 0 0", mif.busy, mif.done);
      end
      $display("test_back_to_back spacing=%0d -> %h_%h", n2 + 1, mif.hi, mif.lo);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      clear     = 1'b1;
      mif.start = 1'b0;
      mif.x     = '0;
      mif.y     = '0;
      test_reset();
      test_basic();
      test_vectors();
      test_start_ignored();
      test_clear_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
